// File: rtl/priority_encoder_pipe_if.sv
// priority_encoder_pipe_if: valid/ready bus carrying input words and encoded results.
//   master: producer/consumer side; drives data_i, data_val_i and data_ready_i.
//   slave : encoder side; drives data_ready_o, the result fields and data_val_o.
interface priority_encoder_pipe_if #(
    parameter int WIDTH = 16
);
    localparam int IDX_W = $clog2(WIDTH);
    logic [WIDTH-1:0] data_i;
    logic             data_val_i;
    logic             data_ready_o;
    logic [WIDTH-1:0] data_left_o;
    logic [WIDTH-1:0] data_right_o;
    logic [IDX_W-1:0] left_idx_o;
    logic [IDX_W-1:0] right_idx_o;
    logic             zero_o;
    logic             data_val_o;
    logic             data_ready_i;
    modport master (
        output data_i, data_val_i, data_ready_i,
        input  data_ready_o, data_left_o, data_right_o, left_idx_o, right_idx_o, zero_o, data_val_o
    );
    modport slave (
        input  data_i, data_val_i, data_ready_i,
        output data_ready_o, data_left_o, data_right_o, left_idx_o, right_idx_o, zero_o, data_val_o
    );
endinterface

// File: rtl/priority_encoder_pipe.sv
// priority_encoder_pipe: two-stage valid/ready priority encoder (highest and lowest set bit).
//   clk_i  : clock, rising edge
//   srst_i : asynchronous active-high reset, clears both stages
//   bus    : slave side of priority_encoder_pipe_if (input word in, one-hots/indices/zero out)
module priority_encoder_pipe #(
    parameter  int WIDTH = 16,
    localparam int IDX_W = $clog2(WIDTH)
) (
    input logic                    clk_i,
    input logic                    srst_i,
    priority_encoder_pipe_if.slave bus
);
    logic             r_v0;
    logic [WIDTH-1:0] r_s0;
    logic             r_v1;
    logic [WIDTH-1:0] r_left;
    logic [WIDTH-1:0] r_right;
    logic [IDX_W-1:0] r_lidx;
    logic [IDX_W-1:0] r_ridx;
    logic             r_zero;
    logic             w_en0;
    logic             w_en1;
    logic [WIDTH-1:0] w_left;
    logic [WIDTH-1:0] w_right;
    logic [IDX_W-1:0] w_lidx;
    logic [IDX_W-1:0] w_ridx;

    // Each stage may load when it is empty or when the stage after it is moving.
    assign w_en1 = !r_v1 || bus.data_ready_i;
    assign w_en0 = !r_v0 || w_en1;
    assign w_right = r_s0 & (~r_s0 + WIDTH'(1));

    // Ascending scan: the last set bit seen is the highest one.
    always_comb begin
        w_left = '0;
        w_lidx = '0;
        w_ridx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (r_s0[i]) begin
                w_left    = '0;
                w_left[i] = 1'b1;
                w_lidx    = IDX_W'(i);
            end
            if (w_right[i]) w_ridx = IDX_W'(i);
        end
    end

    always_ff @(posedge clk_i or posedge srst_i) begin
        if (srst_i) begin
            r_v0    <= 1'b0;
            r_s0    <= '0;
            r_v1    <= 1'b0;
            r_left  <= '0;
            r_right <= '0;
            r_lidx  <= '0;
            r_ridx  <= '0;
            r_zero  <= 1'b0;
        end else begin
            if (w_en0) begin
                r_v0 <= bus.data_val_i;
                r_s0 <= bus.data_i;
            end
            if (w_en1) begin
                r_v1    <= r_v0;
                r_left  <= w_left;
                r_right <= w_right;
                r_lidx  <= w_lidx;
                r_ridx  <= w_ridx;
                r_zero  <= (r_s0 == '0);
            end
        end
    end

    assign bus.data_ready_o = w_en0;
    assign bus.data_val_o   = r_v1;
    assign bus.data_left_o  = r_left;
    assign bus.data_right_o = r_right;
    assign bus.left_idx_o   = r_lidx;
    assign bus.right_idx_o  = r_ridx;
    assign bus.zero_o       = r_zero;
endmodule

// File: tb/tb_priority_encoder_pipe.sv
// tb_priority_encoder_pipe: scoreboard bench for priority_encoder_pipe (WIDTH=16 and WIDTH=5).
module tb_priority_encoder_pipe;
    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
        logic [3:0]  li;
        logic [3:0]  ri;
        logic        z;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   acc = 0;
    res_t q[$];
    res_t held;
    res_t e;
    logic stalled = 1'b0;

    priority_encoder_pipe_if #(.WIDTH(16)) b ();
    priority_encoder_pipe_if #(.WIDTH(5))  b5 ();

    priority_encoder_pipe #(.WIDTH(16)) dut (.clk_i(clk), .srst_i(rst), .bus(b));
    priority_encoder_pipe #(.WIDTH(5))  dut5 (.clk_i(clk), .srst_i(rst), .bus(b5));

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
        checks++;
        if (a !== x) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h t=%0t", n, a, x, $time);
        end
    endtask

    // Reference: highest bit via ceil-log2 of (w+1), lowest bit via two's-complement isolation.
    function automatic res_t model(input logic [15:0] w);
        res_t m;
        int   v;
        int   lo;
        int   hi;
        v = int'(w);
        m = '{16'h0, 16'h0, 4'h0, 4'h0, 1'b1};
        if (v != 0) begin
            lo   = v & -v;
            hi   = $clog2(v + 1) - 1;
            m.l  = 16'(1 << hi);
            m.r  = 16'(lo);
            m.li = 4'(hi);
            m.ri = 4'($clog2(lo));
            m.z  = 1'b0;
        end
        return m;
    endfunction

    task automatic cyc(input logic v, input logic [15:0] d, input logic rd);
        @(posedge clk);
        #1;
        b.data_val_i   = v;
        b.data_i       = d;
        b.data_ready_i = rd;
        @(negedge clk);
        if (!rst && v && b.data_ready_o) begin
            q.push_back(model(d));
            acc++;
        end
    endtask

    always @(negedge clk) begin
        if (rst) stalled = 1'b0;
        else begin
            if (stalled) begin
                chk("stall_val", b.data_val_o, 1'b1);
                chk("stall_left", b.data_left_o, held.l);
                chk("stall_right", b.data_right_o, held.r);
                chk("stall_lidx", b.left_idx_o, held.li);
                chk("stall_ridx", b.right_idx_o, held.ri);
                chk("stall_zero", b.zero_o, held.z);
            end
            if (b.data_val_o && b.data_ready_i) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected_output got=%0h expected=none t=%0t", b.data_left_o, $time);
                end else begin
                    e = q.pop_front();
                    chk("sb_left", b.data_left_o, e.l);
                    chk("sb_right", b.data_right_o, e.r);
                    chk("sb_lidx", b.left_idx_o, e.li);
                    chk("sb_ridx", b.right_idx_o, e.ri);
                    chk("sb_zero", b.zero_o, e.z);
                end
                stalled = 1'b0;
            end else if (b.data_val_o) begin
                stalled = 1'b1;
                held = '{b.data_left_o, b.data_right_o, b.left_idx_o, b.right_idx_o, b.zero_o};
            end else stalled = 1'b0;
        end
    end

    initial begin
        int n;
        int a0;
        int cyc_cnt;
        b.data_i = '0;
        b.data_val_i = 1'b0;
        b.data_ready_i = 1'b0;
        b5.data_i = 5'b10110;
        b5.data_val_i = 1'b1;
        b5.data_ready_i = 1'b1;
        #12;
        chk("rst_val", b.data_val_o, 1'b0);
        chk("rst_zero", b.zero_o, 1'b0);
        chk("rst_left", b.data_left_o, 16'h0);
        chk("rst_right", b.data_right_o, 16'h0);
        chk("rst_idx", {b.left_idx_o, b.right_idx_o}, 8'h0);
        chk("rst_ready", b.data_ready_o, 1'b1);
        rst = 1'b0;
        cyc(1'b1, 16'h0A50, 1'b1);
        cyc(1'b0, 16'h0, 1'b1);
        chk("lat_not_yet", b.data_val_o, 1'b0);
        cyc(1'b0, 16'h0, 1'b1);
        chk("lat_valid", b.data_val_o, 1'b1);
        chk("basic_left", b.data_left_o, 16'h0800);
        chk("basic_lidx", b.left_idx_o, 4'd11);
        foreach (q[i]) chk("unused", 0, 0);
        cyc(1'b1, 16'h0000, 1'b1);
        cyc(1'b1, 16'h8000, 1'b1);
        cyc(1'b1, 16'h0001, 1'b1);
        cyc(1'b1, 16'hFFFF, 1'b1);
        repeat (3) cyc(1'b0, 16'h0, 1'b1);
        n = acc;
        cyc(1'b1, 16'h1234, 1'b0);
        cyc(1'b1, 16'h0040, 1'b0);
        cyc(1'b1, 16'hC001, 1'b0);
        chk("bp_ready_low", b.data_ready_o, 1'b0);
        repeat (3) cyc(1'b1, 16'hC001, 1'b0);
        chk("bp_accepted", acc - n, 2);
        chk("bp_val_held", b.data_val_o, 1'b1);
        chk("bp_word1_left", b.data_left_o, 16'h1000);
        cyc(1'b1, 16'hC001, 1'b1);
        chk("bp_release_ready", b.data_ready_o, 1'b1);
        repeat (4) cyc(1'b0, 16'h0, 1'b1);
        chk("bp_drained", q.size(), 0);
        cyc(1'b1, 16'h00F0, 1'b0);
        cyc(1'b1, 16'h0F00, 1'b0);
        @(posedge clk);
        #3;
        b.data_val_i = 1'b0;
        rst = 1'b1;
        #1;
        chk("mrst_val", b.data_val_o, 1'b0);
        chk("mrst_outs", {b.data_left_o, b.data_right_o}, 32'h0);
        chk("mrst_idx_zero", {b.left_idx_o, b.right_idx_o, b.zero_o}, 9'h0);
        chk("mrst_ready", b.data_ready_o, 1'b1);
        q.delete();
        @(negedge clk);
        b.data_val_i = 1'b1;
        b.data_i = 16'h0300;
        b.data_ready_i = 1'b1;
        #2;
        rst = 1'b0;
        q.push_back(model(16'h0300));
        acc++;
        repeat (3) cyc(1'b0, 16'h0, 1'b1);
        chk("mrst_first_out", q.size(), 0);
        a0 = acc;
        cyc_cnt = 0;
        while (acc - a0 < 10000 && cyc_cnt < 60000) begin
            cyc(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)));
            cyc_cnt++;
        end
        chk("rand_count", (acc - a0 >= 10000) ? 1 : 0, 1);
        repeat (5) cyc(1'b0, 16'h0, 1'b1);
        chk("drain_empty", q.size(), 0);
        chk("w5_val", b5.data_val_o, 1'b1);
        chk("w5_left", b5.data_left_o, 5'b10000);
        chk("w5_right", b5.data_right_o, 5'b00010);
        chk("w5_lidx", b5.left_idx_o, 3'd4);
        chk("w5_ridx", b5.right_idx_o, 3'd1);
        chk("w5_zero", b5.zero_o, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/priority_encoder_pipe.md
# priority_encoder_pipe

Streaming, parametrised two-stage priority encoder with valid/ready flow control. It reports both the most-significant set bit (left) and the least-significant set bit (right) of each input word, as one-hot masks, binary indices and a zero flag. It sits between any valid/ready producer and consumer in the datapath. It replaces the unflow-controlled single-cycle encoder wherever the downstream can stall.

## Interface

Parameters:
- WIDTH, 16: input word width; legal range is WIDTH >= 2 (need not be a power of two).
- IDX_W, $clog2(WIDTH): index width; derived, not overridden.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- srst_i  in  1  reset, asynchronous, active-high; clears all state immediately.
- data_i  in  WIDTH  word to encode.
- data_val_i  in  1  data_i valid.
- data_ready_o  out  1  block can accept data_i this cycle.
- data_left_o  out  WIDTH  one-hot of the highest set bit of the word.
- data_right_o  out  WIDTH  one-hot of the lowest set bit of the word.
- left_idx_o  out  IDX_W  binary index of the highest set bit.
- right_idx_o  out  IDX_W  binary index of the lowest set bit.
- zero_o  out  1  word was all zeros.
- data_val_o  out  1  result outputs valid.
- data_ready_i  in  1  consumer accepts the result this cycle.

## Operation

- Input transfer: occurs on any cycle where data_val_i && data_ready_o. Output transfer: occurs on any cycle where data_val_o && data_ready_i.
- Stage 0 (S0):
  - Register holding the raw word plus valid bit v0.
  - Captures data_i when en0; on that edge, v0 <= data_val_i.
- Stage 1 (S1):
  - Holds the computed result plus valid bit v1. All outputs are driven directly from S1 registers.
  - Loads from S0 when en1; on that edge, v1 <= v0.
- Enables (bubble-collapsing):
  - en1 = !v1 || data_ready_i.
  - en0 = !v0 || en1.
  - data_ready_o = en0. This is a combinational path from data_ready_i; it is permitted.
- Encode logic between S0 and S1, for word w:
  - right one-hot = w & (~w + 1), truncated to WIDTH.
  - left one-hot = only the highest set bit of w.
  - Indices are binary encodings of those bit positions.
  - zero = (w == 0).
- All-zero word: still produces a valid result. Required values are left/right one-hot = 0, both indices = 0, zero_o = 1.
- Single-bit word: left and right outputs are equal, and left_idx_o == right_idx_o.
- When data_val_o is low, result outputs hold their last loaded values. The bench must not check them in that state.
- Stall: while data_val_o && !data_ready_i, all result outputs and data_val_o hold stable.
- No word is dropped or duplicated. Output order equals input order.
- Reset: asynchronous assertion clears v0, v1 and all S0/S1 data registers to 0.
  - Outputs during and after reset are 0 (data_val_o = 0, zero_o = 0, indices = 0, one-hots = 0).
  - data_ready_o = 1 while v0 = v1 = 0, which includes during reset.
  - Transfers presented while srst_i is high are discarded.
  - Reset mid-stream flushes both stages; any in-flight words are lost.

## Timing

- Latency: an input accepted at edge N appears on the outputs after edge N+1, if S1 is free.
- Throughput: one word per cycle while data_ready_i is held high.
- Capacity: 2 words. With data_ready_i low, the block accepts exactly two words, then data_ready_o goes low.
- Simultaneous output and input transfer with both stages full is allowed:
  - S1 takes the S0 word.
  - S0 takes the new data_i.
- Releasing a stall: data_ready_o returns high in the same cycle that data_ready_i rises.
- Reset release: the first input can be accepted on the first rising edge after srst_i deasserts.

## Test plan

- Basic, WIDTH=16, data_ready_i=1, input 16'h0A50 -> one cycle later:
  - data_left_o=16'h0800, data_right_o=16'h0010, left_idx_o=11, right_idx_o=4, zero_o=0, data_val_o=1.
- Corner words, WIDTH=16:
  - 16'h0000 -> zero_o=1, both one-hots 0, both indices 0.
  - 16'h8000 -> left=right=16'h8000, both indices 15.
  - 16'h0001 -> left=right=16'h0001, both indices 0.
  - 16'hFFFF -> left 16'h8000 (idx 15), right 16'h0001 (idx 0).
- Backpressure: hold data_ready_i=0 and stream 3 words ->
  - Only 2 are accepted; data_ready_o falls after the second.
  - Outputs stay stable on word 1.
  - Raise data_ready_i -> words 1, 2, 3 emerge in order with no loss.
- Random stream: 10k random words, with random data_val_i and data_ready_i at 50% each -> the scoreboard matches a reference model exactly, in order, with no drops or duplicates.
- Reset mid-stream: assert srst_i asynchronously between edges with both stages full ->
  - data_val_o drops immediately and all outputs go to 0.
  - After release, the next word is encoded correctly with no stale output.
- Non-power-of-two WIDTH=5 (IDX_W=3): input 5'b10110 -> left 5'b10000 (idx 4), right 5'b00010 (idx 1).
